// File: rtl/rst_cipher_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rst_cipher_pkg
//  Purpose  : Shared definitions for the Rotary Substitution Table (RST)
//             encryptor and decryptor: key/table geometry, ASCII bounds,
//             table types and the load/rotate helpers both ends must share.
//  Revision : 1.0  initial release
// ============================================================================
package rst_cipher_pkg;

    localparam int KEY_LEN   = 12;
    localparam int TABLE_DIM = 6;

    localparam logic [7:0] c_CHAR_A  = 8'h41;  // 'A'
    localparam logic [7:0] c_CHAR_Z  = 8'h5A;  // 'Z'
    localparam logic [7:0] c_CHAR_LA = 8'h61;  // 'a'
    localparam logic [7:0] c_CHAR_LZ = 8'h7A;  // 'z'
    localparam logic [7:0] c_CHAR_0  = 8'h30;  // '0'
    localparam logic [7:0] c_CHAR_9  = 8'h39;  // '9'

    // Key as presented on the port: element [11] is the first character.
    typedef logic [KEY_LEN-1:0][7:0] key_t;

    // Rotary table: entries [0..5] are row characters R0..R5,
    // entries [6..11] are column characters C0..C5.
    typedef logic [KEY_LEN-1:0][7:0] rot_table_t;

    function automatic logic is_alnum(input logic [7:0] b);
        return ((b >= c_CHAR_0)  && (b <= c_CHAR_9))  ||
               ((b >= c_CHAR_A)  && (b <= c_CHAR_Z))  ||
               ((b >= c_CHAR_LA) && (b <= c_CHAR_LZ));
    endfunction

    // Rows take the even key positions counted from the first character,
    // columns take the odd ones, interleaved from both ends of the key.
    function automatic rot_table_t load_table(input key_t k);
        rot_table_t t;
        t[0]  = k[11];
        t[1]  = k[1];
        t[2]  = k[9];
        t[3]  = k[3];
        t[4]  = k[7];
        t[5]  = k[5];
        t[6]  = k[10];
        t[7]  = k[0];
        t[8]  = k[8];
        t[9]  = k[2];
        t[10] = k[6];
        t[11] = k[4];
        return t;
    endfunction

    // Both halves rotate by one position: the last entry wraps to the front.
    function automatic rot_table_t rotate_table(input rot_table_t t);
        rot_table_t r;
        r[0]         = t[TABLE_DIM-1];
        r[TABLE_DIM] = t[KEY_LEN-1];
        for (int i = 1; i < TABLE_DIM; i++) begin
            r[i]             = t[i-1];
            r[TABLE_DIM + i] = t[TABLE_DIM + i - 1];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_rot_table.sv
`default_nettype none
// ============================================================================
//  Module   : rst_rot_table
//  Purpose  : Rotary substitution table register, shared by encryptor and
//             decryptor so that both ends rotate identically.
//  Ports    : clk, rst      - clock / synchronous active-high reset
//             i_clear       - clear table to 8'h00
//             i_load        - load table from i_key
//             i_key         - key string (element [11] first character)
//             i_rotate      - rotate rows and columns by one position
//             o_table       - current table contents
//  Priority : rst / i_clear > i_load > i_rotate
//  Revision : 1.0  initial release
// ============================================================================
module rst_rot_table
    import rst_cipher_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_load,
    input  key_t       i_key,
    input  logic       i_rotate,
    output rot_table_t o_table
);

    rot_table_t r_table;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_table <= '0;
        end else if (i_load) begin
            r_table <= load_table(i_key);
        end else if (i_rotate) begin
            r_table <= rotate_table(r_table);
        end
    end

    assign o_table = r_table;

endmodule
`default_nettype wire

// File: rtl/rst_decipher.sv
`default_nettype none
// ============================================================================
//  Module   : rst_decipher
//  Purpose  : RST decryptor. Installs a 12-character key, rebuilds the 6x6
//             rotary table and turns each {row_char, col_char} ciphertext
//             pair into one plaintext letter/digit, rotating after every
//             successful decode. One character per cycle, latency 1.
//  Ports    : clk, rst               - clock / synchronous active-high reset
//             key_valid, key         - key strobe and key string
//             ctxt_valid, ctxt_str   - ciphertext strobe and pair
//             ptxt_char, ptxt_ready  - decrypted character and its pulse
//             key_installed          - level, valid key loaded
//             err_invalid_key        - pulse, key rejected
//             err_key_not_installed  - pulse, ciphertext with no key
//             err_invalid_ctxt       - pulse, undecodable pair
//  Revision : 1.0  initial release
// ============================================================================
module rst_decipher
    import rst_cipher_pkg::*;
#(
    parameter bit LOWERCASE_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [11:0][7:0] key,
    input  logic             ctxt_valid,
    input  logic [15:0]      ctxt_str,
    output logic [7:0]       ptxt_char,
    output logic             ptxt_ready,
    output logic             key_installed,
    output logic             err_invalid_key,
    output logic             err_key_not_installed,
    output logic             err_invalid_ctxt
);

    localparam logic [0:0] c_ST_NO_KEY = 1'b0;
    localparam logic [0:0] c_ST_READY  = 1'b1;

    logic [0:0] r_state;

    rot_table_t w_table;
    logic       w_key_ok;
    logic       w_row_hit;
    logic       w_col_hit;
    logic [2:0] w_row_idx;
    logic [2:0] w_col_idx;
    logic [5:0] w_cell;
    logic [7:0] w_plain;
    logic       w_decode_ok;

    // Key acceptance: every byte alphanumeric, all bytes pairwise distinct.
    always_comb begin
        w_key_ok = 1'b1;
        for (int i = 0; i < KEY_LEN; i++) begin
            if (!is_alnum(key[i])) begin
                w_key_ok = 1'b0;
            end
            for (int j = i + 1; j < KEY_LEN; j++) begin
                if (key[i] == key[j]) begin
                    w_key_ok = 1'b0;
                end
            end
        end
    end

    // Each byte must be found in its own half; key bytes are unique, so at
    // most one entry per half can match.
    always_comb begin
        w_row_hit = 1'b0;
        w_col_hit = 1'b0;
        w_row_idx = '0;
        w_col_idx = '0;
        for (int i = 0; i < TABLE_DIM; i++) begin
            if (w_table[i] == ctxt_str[15:8]) begin
                w_row_hit = 1'b1;
                w_row_idx = 3'(i);
            end
            if (w_table[TABLE_DIM + i] == ctxt_str[7:0]) begin
                w_col_hit = 1'b1;
                w_col_idx = 3'(i);
            end
        end
    end

    // cell = 6*row + col, formed as 4*row + 2*row + col.
    assign w_cell = {1'b0, w_row_idx, 2'b00} + {2'b00, w_row_idx, 1'b0} + {3'b000, w_col_idx};

    always_comb begin
        if (w_cell < 6'd26) begin
            w_plain = (LOWERCASE_OUT ? c_CHAR_LA : c_CHAR_A) + {2'b00, w_cell};
        end else begin
            w_plain = c_CHAR_0 + {2'b00, w_cell} - 8'd26;
        end
    end

    // A key strobe always wins over a same-cycle ciphertext.
    assign w_decode_ok = !key_valid && ctxt_valid && (r_state == c_ST_READY) &&
                         w_row_hit && w_col_hit;

    rst_rot_table u_table (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (key_valid && !w_key_ok),
        .i_load   (key_valid && w_key_ok),
        .i_key    (key),
        .i_rotate (w_decode_ok),
        .o_table  (w_table)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= c_ST_NO_KEY;
            ptxt_char             <= '0;
            ptxt_ready            <= 1'b0;
            key_installed         <= 1'b0;
            err_invalid_key       <= 1'b0;
            err_key_not_installed <= 1'b0;
            err_invalid_ctxt      <= 1'b0;
        end else begin
            ptxt_ready            <= 1'b0;
            err_invalid_key       <= 1'b0;
            err_key_not_installed <= 1'b0;
            err_invalid_ctxt      <= 1'b0;
            if (key_valid) begin
                if (w_key_ok) begin
                    r_state       <= c_ST_READY;
                    key_installed <= 1'b1;
                end else begin
                    r_state         <= c_ST_NO_KEY;
                    key_installed   <= 1'b0;
                    err_invalid_key <= 1'b1;
                end
            end else if (ctxt_valid) begin
                if (r_state == c_ST_NO_KEY) begin
                    err_key_not_installed <= 1'b1;
                end else if (w_row_hit && w_col_hit) begin
                    ptxt_char  <= w_plain;
                    ptxt_ready <= 1'b1;
                end else begin
                    err_invalid_ctxt <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rst_decipher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_decipher
//  Purpose  : Self-checking bench for rst_decipher. A reference model keeps
//             the loaded rows/columns plus a rotation offset and predicts each
//             cycle's response; a monitor pops the expectations and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rst_decipher;

    localparam bit LC = 1'b0;

    localparam int EV_PTXT   = 0;
    localparam int EV_BADKEY = 1;
    localparam int EV_NOKEY  = 2;
    localparam int EV_BADCT  = 3;
    localparam int EV_NONE   = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_valid;
    logic [11:0][7:0] key;
    logic             ctxt_valid;
    logic [15:0]      ctxt_str;
    logic [7:0]       ptxt_char;
    logic             ptxt_ready;
    logic             key_installed;
    logic             err_invalid_key;
    logic             err_key_not_installed;
    logic             err_invalid_ctxt;

    rst_decipher #(.LOWERCASE_OUT(LC)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .key_valid             (key_valid),
        .key                   (key),
        .ctxt_valid            (ctxt_valid),
        .ctxt_str              (ctxt_str),
        .ptxt_char             (ptxt_char),
        .ptxt_ready            (ptxt_ready),
        .key_installed         (key_installed),
        .err_invalid_key       (err_invalid_key),
        .err_key_not_installed (err_key_not_installed),
        .err_invalid_ctxt      (err_invalid_ctxt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [7:0]  ch;
        int unsigned due;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    // Reference model state
    bit         m_ready = 1'b0;
    logic [7:0] rows_l[6];
    logic [7:0] cols_l[6];
    int         rot = 0;
    logic       exp_ki = 1'b0, nxt_ki = 1'b0;
    logic [7:0] exp_pc = 8'h00, nxt_pc = 8'h00;
    logic [7:0] alnum[62];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit m_alnum(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h5A) ||
               (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic bit m_key_ok(input logic [11:0][7:0] k);
        for (int i = 0; i < 12; i++) begin
            if (!m_alnum(k[i])) return 1'b0;
            for (int j = 0; j < 12; j++)
                if (i != j && k[i] == k[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Current row i of the rotated table is loaded row (i - rot) mod 6.
    function automatic logic [15:0] m_encrypt(input int pidx);
        int r = pidx / 6;
        int c = pidx % 6;
        return {rows_l[(r - rot + 6) % 6], cols_l[(c - rot + 6) % 6]};
    endfunction

    task automatic m_step(input bit r, input bit kv, input logic [11:0][7:0] k,
                          input bit cv, input logic [15:0] c);
        ev_t e;
        int  jr, jc, ri, ci, idx;
        e.due = cyc + 1;
        e.ch  = 8'h00;
        if (r) begin
            m_ready = 1'b0;
            rot     = 0;
            nxt_ki  = 1'b0;
            nxt_pc  = 8'h00;
        end else if (kv) begin
            if (m_key_ok(k)) begin
                rows_l[0] = k[11]; rows_l[1] = k[1]; rows_l[2] = k[9];
                rows_l[3] = k[3];  rows_l[4] = k[7]; rows_l[5] = k[5];
                cols_l[0] = k[10]; cols_l[1] = k[0]; cols_l[2] = k[8];
                cols_l[3] = k[2];  cols_l[4] = k[6]; cols_l[5] = k[4];
                rot     = 0;
                m_ready = 1'b1;
                nxt_ki  = 1'b1;
            end else begin
                m_ready = 1'b0;
                nxt_ki  = 1'b0;
                e.kind  = EV_BADKEY;
                q.push_back(e);
            end
        end else if (cv) begin
            if (!m_ready) begin
                e.kind = EV_NOKEY;
                q.push_back(e);
            end else begin
                jr = -1;
                jc = -1;
                for (int j = 0; j < 6; j++) begin
                    if (rows_l[j] == c[15:8]) jr = j;
                    if (cols_l[j] == c[7:0])  jc = j;
                end
                if (jr >= 0 && jc >= 0) begin
                    ri  = (jr + rot) % 6;
                    ci  = (jc + rot) % 6;
                    idx = 6 * ri + ci;
                    if (idx < 26) e.ch = 8'((LC ? 97 : 65) + idx);
                    else          e.ch = 8'(48 + idx - 26);
                    e.kind = EV_PTXT;
                    q.push_back(e);
                    nxt_pc = e.ch;
                    rot    = (rot + 1) % 6;
                end else begin
                    e.kind = EV_BADCT;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit kv, input logic [11:0][7:0] k,
                        input bit cv, input logic [15:0] c);
        @(posedge clk);
        #1;
        exp_ki     = nxt_ki;
        exp_pc     = nxt_pc;
        rst        = r;
        key_valid  = kv;
        key        = k;
        ctxt_valid = cv;
        ctxt_str   = c;
        m_step(r, kv, k, cv, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 16'h0);
    endtask

    task automatic send_key(input logic [11:0][7:0] k);
        step(1'b0, 1'b1, k, 1'b0, 16'h0);
    endtask

    task automatic send_ct(input logic [15:0] c);
        step(1'b0, 1'b0, '0, 1'b1, c);
    endtask

    function automatic logic [11:0][7:0] rand_key(input bit valid);
        logic [7:0]       pool[62];
        logic [7:0]       t, b;
        logic [11:0][7:0] k;
        int               j, a, d;
        pool = alnum;
        for (int i = 61; i > 0; i--) begin
            j = $urandom_range(i);
            t = pool[i]; pool[i] = pool[j]; pool[j] = t;
        end
        for (int i = 0; i < 12; i++) k[i] = pool[i];
        if (!valid) begin
            a = $urandom_range(11);
            if ($urandom_range(1) == 0) begin
                d = (a + 1 + $urandom_range(10)) % 12;
                k[a] = k[d];
            end else begin
                b = 8'($urandom_range(255));
                while (m_alnum(b)) b = 8'($urandom_range(255));
                k[a] = b;
            end
        end
        return k;
    endfunction

    // Monitor: levels every cycle, pulses against the scoreboard queue.
    always @(negedge clk) begin
        int  n;
        int  dk;
        ev_t e;
        if (mon_en) begin
            n = int'(ptxt_ready) + int'(err_invalid_key) +
                int'(err_key_not_installed) + int'(err_invalid_ctxt);
            if (ptxt_ready)                 dk = EV_PTXT;
            else if (err_invalid_key)       dk = EV_BADKEY;
            else if (err_key_not_installed) dk = EV_NOKEY;
            else if (err_invalid_ctxt)      dk = EV_BADCT;
            else                            dk = EV_NONE;
            chk("key_installed", 32'(key_installed), 32'(exp_ki));
            chk("ptxt_char_level", 32'(ptxt_char), 32'(exp_pc));
            if (n > 1) chk("pulse_exclusive", 32'(n), 32'd1);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("event_kind", 32'(dk), 32'(e.kind));
                if (e.kind == EV_PTXT) chk("ptxt_value", 32'(ptxt_char), 32'(e.ch));
            end else if (n != 0) begin
                chk("unexpected_pulse", 32'(dk), 32'(EV_NONE));
            end
        end
    end

    int pidx;
    logic [7:0] pc;

    initial begin
        for (int i = 0; i < 10; i++) alnum[i]      = 8'(48 + i);
        for (int i = 0; i < 26; i++) alnum[10 + i] = 8'(65 + i);
        for (int i = 0; i < 26; i++) alnum[36 + i] = 8'(97 + i);

        rst = 1'b1; key_valid = 1'b0; key = '0; ctxt_valid = 1'b0; ctxt_str = '0;
        step(1'b1, 1'b0, '0, 1'b0, 16'h0);
        step(1'b1, 1'b0, '0, 1'b0, 16'h0);
        step(1'b0, 1'b0, '0, 1'b0, 16'h0);
        @(negedge clk);
        chk("rst_ptxt_char", 32'(ptxt_char), 32'd0);
        chk("rst_ptxt_ready", 32'(ptxt_ready), 32'd0);
        chk("rst_key_installed", 32'(key_installed), 32'd0);
        chk("rst_err_invalid_key", 32'(err_invalid_key), 32'd0);
        chk("rst_err_key_not_inst", 32'(err_key_not_installed), 32'd0);
        chk("rst_err_invalid_ctxt", 32'(err_invalid_ctxt), 32'd0);
        mon_en = 1'b1;

        // HELLO with a sequential key
        send_key("ABCDEFGHIJKL");
        send_ct("KL"); send_ct("GJ"); send_ct("GJ"); send_ct("ED"); send_ct("EF");
        idle(2);

        // Round trip of the full alphabet with a lowercase key
        send_key("abcdefghijkl");
        for (int i = 0; i < 62; i++) begin
            pc = alnum[(i < 52) ? 10 + i : i - 52];
            if (pc >= 8'h61)      pidx = int'(pc) - 97;
            else if (pc >= 8'h41) pidx = int'(pc) - 65;
            else                  pidx = int'(pc) - 48 + 26;
            send_ct(m_encrypt(pidx));
        end
        idle(2);

        // Rejected keys, then ciphertext with no key
        send_key("ABC?*-.HIJKL");
        idle(1);
        send_key("ABCDEFGHDDKL");
        send_ct("KL");
        idle(2);

        // Invalid pair does not rotate
        send_key("ABCDEFGHIJKL");
        send_ct("KL"); send_ct("ZZ"); send_ct("GJ");
        idle(2);

        // Key and ciphertext together: key wins, rotation restarts
        send_ct("KL");
        step(1'b0, 1'b1, "ABCDEFGHIJKL", 1'b1, "GJ");
        send_ct("KL");
        idle(2);

        // Reset mid-stream
        send_ct("GJ"); send_ct("GJ"); send_ct("ED");
        step(1'b1, 1'b0, '0, 1'b0, 16'h0);
        idle(1);
        send_ct("KL");
        idle(2);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = $urandom_range(999);
            if (sel < 5) begin
                step(1'b1, 1'b0, '0, 1'b0, 16'h0);
            end else if (sel < 55) begin
                step(1'b0, 1'b1, rand_key($urandom_range(99) < 80), $urandom_range(1) == 1,
                     16'($urandom()));
            end else if (sel < 750) begin
                if (m_ready && $urandom_range(99) < 80) begin
                    send_ct(m_encrypt($urandom_range(35)));
                end else if (m_ready && $urandom_range(1) == 1) begin
                    send_ct({cols_l[$urandom_range(5)], rows_l[$urandom_range(5)]});
                end else begin
                    send_ct(16'($urandom()));
                end
            end else begin
                idle(1);
            end
        end
        idle(3);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rst_decipher.md
Name: rst_decipher

Overview:
Decryption counterpart of the Rotary Substitution Table (RST) encryption module. It installs the same 12-character key and rebuilds the identical 6x6 rotary table. For each 16-bit ciphertext pair it locates the row and column characters, maps the resulting cell index back to a plaintext letter or digit, then rotates the table exactly as the encryptor does. It sits at the receive end of the RST link, fed by the encryptor's ctxt_str stream.

Parameters:
LOWERCASE_OUT, 0, 1 = letters returned as 'a'..'z'; 0 = 'A'..'Z'. The cipher is case-insensitive, so case is not recoverable from ciphertext.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
key_valid  in  1  one-cycle strobe; sample key this cycle
key  in  [11:0][7:0]  key string; key[11] is the first character
ctxt_valid  in  1  one-cycle strobe; ctxt_str valid this cycle
ctxt_str  in  16  {row_char[15:8], col_char[7:0]}
ptxt_char  out  8  decrypted ASCII character
ptxt_ready  out  1  ptxt_char valid this cycle (one-cycle pulse)
key_installed  out  1  level; high when a valid key is loaded
err_invalid_key  out  1  one-cycle pulse; rejected key
err_key_not_installed  out  1  one-cycle pulse; ctxt_valid seen with no key
err_invalid_ctxt  out  1  one-cycle pulse; undecodable ciphertext pair

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, table cleared to 8'h00, FSM to NO_KEY. Reset mid-stream discards any in-flight result; the next cycle's outputs are all 0.
- FSM has two states. NO_KEY -> READY on an accepted key. READY -> READY on an accepted key (reload). Either state -> NO_KEY on a rejected key.
- Key check, one cycle: all 12 bytes must be in [0-9A-Za-z], and no two bytes may be equal (exact byte compare). key_valid sampled at edge N -> key_installed or err_invalid_key updates at N+1.
- Table load order: rows R0..R5 = key[11],key[1],key[9],key[3],key[7],key[5]. Columns C0..C5 = key[10],key[0],key[8],key[2],key[6],key[4].
- Decode: r = position of row_char in R0..R5 and c = position of col_char in C0..C5. The byte must be found in its own half of the table. idx = 6r+c.
  - idx 0..25 -> 'A'+idx, or 'a'+idx when LOWERCASE_OUT=1.
  - idx 26..35 -> '0'+(idx-26).
  - idx fits in 6 bits.
- Latency: ctxt_valid at edge N -> ptxt_ready/ptxt_char at N+1. Throughput is one character per cycle, back-to-back, no stalls.
- Rotation happens only after a successful decode, in the same edge the result registers:
  - R0<=R5, Ri<=Ri-1.
  - C0<=C5, Ci<=Ci-1.
  - Period is 6 characters; after 6 decodes the table equals its just-loaded state.
- Error cases, each with no rotation and ptxt_ready=0:
  - row_char or col_char not found -> err_invalid_ctxt.
  - ctxt_valid while NO_KEY -> err_key_not_installed; ptxt_char stays 0.
- Simultaneous key_valid and ctxt_valid: the key takes priority. The ciphertext is dropped silently (no error pulse), and a successful key reload resets rotation to the load state.
- ptxt_char holds its last value when ptxt_ready=0. Error pulses are mutually exclusive in any one cycle.

Decomposition:
- Shared package rst_cipher_pkg, common with the encryptor:
  - KEY_LEN=12 and TABLE_DIM=6.
  - ASCII constants for 'A','Z','a','z','0','9'.
  - typedef rot_table_t (12 x 8-bit).
  - Functions is_alnum(byte), load_table(key) and rotate_table(t).
- One sub-module, rst_rot_table: holds the table register with load/rotate/clear controls. The encryptor reuses it, which guarantees both ends rotate identically.

Test Plan:
1. Key "ABCDEFGHIJKL" strobe, then ctxt "KL","GJ","GJ","ED","EF" on consecutive cycles -> ptxt "H","E","L","L","O", ptxt_ready high 5 consecutive cycles, latency 1.
2. Round trip: key "abcdefghijkl", feed the 62 encryptor outputs for "A".."Z","a".."z","0".."9" back-to-back -> ptxt "A".."Z","A".."Z","0".."9" in order (LOWERCASE_OUT=0).
3. Key "ABC?*-.HIJKL" -> err_invalid_key one cycle, key_installed=0. Key "ABCDEFGHDDKL" -> err_invalid_key. Then ctxt "KL" -> err_key_not_installed, ptxt_ready=0.
4. Valid key ABCDEFGHIJKL, ctxt "KL" -> 'H'. Then "ZZ" -> err_invalid_ctxt, no rotation. Then "GJ" -> 'E', proving the table did not rotate on the error.
5. "KL" -> 'H', then key_valid with ABCDEFGHIJKL together with ctxt "GJ" -> no ptxt_ready, no error. Next "KL" -> 'H', proving rotation reset.
6. rst asserted after 3 decodes -> all outputs 0, key_installed=0. Then ctxt "KL" -> err_key_not_installed.
